// File: rtl/ste_avg_pkg.sv
// rtl/ste_avg_pkg.sv - shared constants and helpers for the multi-channel IIR averager
//
// Purpose: default widths of the averager family and the shift clamp used by
//          every averager variant, so all of them agree on how an out-of-range
//          k is interpreted.
// Contents: SHIFT_W (width of the k input), default DATA_W / FRAC_W / SHIFT_MAX,
//           clamp_shift() which limits a requested k to the supported maximum.
package ste_avg_pkg;

    localparam int SHIFT_W       = 4;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_FRAC_W    = 4;
    localparam int DEF_SHIFT_MAX = 7;

    // Requests above shift_max saturate rather than wrap, so an over-large k
    // still gives the heaviest supported smoothing.
    function automatic logic [SHIFT_W-1:0] clamp_shift(
        input logic [SHIFT_W-1:0] shift,
        input int                 shift_max
    );
        return (int'(shift) > shift_max) ? SHIFT_W'(shift_max) : shift;
    endfunction

endpackage

// File: rtl/ste_avg_iir_dp.sv
// rtl/ste_avg_iir_dp.sv - combinational single-sample update of one averager channel
//
// Purpose: given the stored state of the channel a sample belongs to, produce
//          that channel's next state and the values presented on the outputs.
// Ports:
//   din      in   DATA_W     incoming sample
//   shift    in   SHIFT_W    k, already clamped to SHIFT_MAX
//   acc      in   AW         current accumulator (DATA_W integer + FRAC_W guard bits)
//   seeded   in   1          channel has taken a sample since its last clear
//   cnt      in   CNT_W      samples since clear, saturating at 2^SHIFT_MAX
//   acc_new  out  AW         next accumulator
//   cnt_new  out  CNT_W      next sample count
//   dout     out  DATA_W     integer part of acc_new (fraction truncated)
//   settled  out  1          cnt_new >= 2^k
module ste_avg_iir_dp
    import ste_avg_pkg::*;
#(
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int FRAC_W    = DEF_FRAC_W,
    parameter  int SHIFT_MAX = DEF_SHIFT_MAX,
    localparam int AW        = DATA_W + FRAC_W,
    localparam int CNT_W     = SHIFT_MAX + 1
) (
    input  logic [DATA_W-1:0]  din,
    input  logic [SHIFT_W-1:0] shift,
    input  logic [AW-1:0]      acc,
    input  logic               seeded,
    input  logic [CNT_W-1:0]   cnt,
    output logic [AW-1:0]      acc_new,
    output logic [CNT_W-1:0]   cnt_new,
    output logic [DATA_W-1:0]  dout,
    output logic               settled
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(1) << SHIFT_MAX;

    logic [AW-1:0]        x;
    logic signed [AW:0]   diff;
    logic signed [AW:0]   step;

    always_comb begin
        x    = AW'(din) << FRAC_W;
        // One extra bit keeps the difference signed without overflow.
        diff = $signed({1'b0, x}) - $signed({1'b0, acc});
        // Arithmetic shift rounds toward minus infinity; acc + step always lands
        // between acc and x, so the truncation back to AW bits cannot wrap.
        step = diff >>> shift;

        if (seeded) begin
            acc_new = AW'($unsigned({1'b0, acc}) + $unsigned(step));
            cnt_new = (cnt >= CNT_SAT) ? cnt : cnt + CNT_W'(1);
        end else begin
            // First sample after a clear loads the accumulator directly so the
            // output does not ramp up from zero.
            acc_new = x;
            cnt_new = CNT_W'(1);
        end
    end

    assign dout    = acc_new[AW-1:FRAC_W];
    assign settled = (cnt_new >= (CNT_W'(1) << shift));

endmodule

// File: rtl/ste_avg_iir_mc.sv
// rtl/ste_avg_iir_mc.sv - time-multiplexed multi-channel first-order IIR averager
//
// Purpose: y[n] = y[n-1] + (x[n] - y[n-1]) * 2^-k kept independently for CH_N
//          interleaved channels over one shared update datapath. One sample per
//          clock, result one clock later, no stalls.
// Ports:
//   clk             in   1        system clock
//   rst_n           in   1        synchronous active-low reset
//   din_i           in   DATA_W   input sample
//   din_ch_i        in   CH_W     channel of din_i
//   din_vld_i       in   1        sample valid
//   shift_i         in   4        k (clamped to SHIFT_MAX)
//   avg_en_i        in   1        global enable; samples ignored while low
//   avg_clr_i       in   1        clear every channel
//   ch_clr_i        in   1        clear the channel named by ch_clr_sel_i
//   ch_clr_sel_i    in   CH_W     channel cleared by ch_clr_i
//   dout_o          out  DATA_W   averaged value of dout_ch_o
//   dout_ch_o       out  CH_W     channel of the current output
//   dout_update_o   out  1        one-cycle strobe marking a new dout_o
//   dout_settled_o  out  1        channel has taken at least 2^k samples since clear
module ste_avg_iir_mc
    import ste_avg_pkg::*;
#(
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int CH_N      = 4,
    parameter  int FRAC_W    = DEF_FRAC_W,
    parameter  int SHIFT_MAX = DEF_SHIFT_MAX,
    localparam int CH_W      = (CH_N > 1) ? $clog2(CH_N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  din_i,
    input  logic [CH_W-1:0]    din_ch_i,
    input  logic               din_vld_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic               avg_en_i,
    input  logic               avg_clr_i,
    input  logic               ch_clr_i,
    input  logic [CH_W-1:0]    ch_clr_sel_i,
    output logic [DATA_W-1:0]  dout_o,
    output logic [CH_W-1:0]    dout_ch_o,
    output logic               dout_update_o,
    output logic               dout_settled_o
);

    localparam int AW    = DATA_W + FRAC_W;
    localparam int CNT_W = SHIFT_MAX + 1;

    // Per-channel state.
    logic [AW-1:0]    acc    [CH_N];
    logic [CNT_W-1:0] cnt    [CH_N];
    logic [CH_N-1:0]  seeded;

    // State of the addressed channel and the clear/accept decisions.
    logic [AW-1:0]        sel_acc;
    logic [CNT_W-1:0]     sel_cnt;
    logic                 sel_seeded;
    logic                 ch_ok;
    logic                 ch_hit_clr;
    logic [CH_N-1:0]      clr_vec;
    logic                 accept;
    logic [SHIFT_W-1:0]   k;

    // Datapath results.
    logic [AW-1:0]        acc_new;
    logic [CNT_W-1:0]     cnt_new;
    logic [DATA_W-1:0]    dp_dout;
    logic                 dp_settled;

    assign k = clamp_shift(shift_i, SHIFT_MAX);

    // Channel lookup is a decode over the real channels, so a tag beyond
    // CH_N-1 (possible when CH_N is not a power of two) matches nothing and
    // the sample is dropped.
    always_comb begin
        ch_ok      = 1'b0;
        ch_hit_clr = 1'b0;
        sel_acc    = '0;
        sel_cnt    = '0;
        sel_seeded = 1'b0;
        clr_vec    = '0;
        for (int c = 0; c < CH_N; c++) begin
            clr_vec[c] = avg_clr_i | (ch_clr_i & (ch_clr_sel_i == CH_W'(c)));
            if (din_ch_i == CH_W'(c)) begin
                ch_ok      = 1'b1;
                ch_hit_clr = clr_vec[c];
                sel_acc    = acc[c];
                sel_cnt    = cnt[c];
                sel_seeded = seeded[c];
            end
        end
    end

    // A clear on the sample's own channel wins and the sample is lost.
    assign accept = din_vld_i & avg_en_i & ch_ok & ~ch_hit_clr;

    ste_avg_iir_dp #(
        .DATA_W    (DATA_W),
        .FRAC_W    (FRAC_W),
        .SHIFT_MAX (SHIFT_MAX)
    ) u_dp (
        .din     (din_i),
        .shift   (k),
        .acc     (sel_acc),
        .seeded  (sel_seeded),
        .cnt     (sel_cnt),
        .acc_new (acc_new),
        .cnt_new (cnt_new),
        .dout    (dp_dout),
        .settled (dp_settled)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < CH_N; c++) begin
                acc[c] <= '0;
                cnt[c] <= '0;
            end
            seeded         <= '0;
            dout_o         <= '0;
            dout_ch_o      <= '0;
            dout_update_o  <= 1'b0;
            dout_settled_o <= 1'b0;
        end else begin
            for (int c = 0; c < CH_N; c++) begin
                if (clr_vec[c]) begin
                    acc[c]    <= '0;
                    cnt[c]    <= '0;
                    seeded[c] <= 1'b0;
                end else if (accept && (din_ch_i == CH_W'(c))) begin
                    acc[c]    <= acc_new;
                    cnt[c]    <= cnt_new;
                    seeded[c] <= 1'b1;
                end
            end

            dout_update_o <= accept;
            // Outputs only move on an accepted sample; clears leave them alone.
            if (accept) begin
                dout_o         <= dp_dout;
                dout_ch_o      <= din_ch_i;
                dout_settled_o <= dp_settled;
            end
        end
    end

endmodule

// File: tb/tb_ste_avg_iir_mc.sv
// tb/tb_ste_avg_iir_mc.sv - self-checking bench for ste_avg_iir_mc
module tb_ste_avg_iir_mc;

    localparam int DATA_W    = 16;
    localparam int CH_N      = 3;
    localparam int FRAC_W    = 4;
    localparam int SHIFT_MAX = 7;
    localparam int CNT_CAP   = 1 << SHIFT_MAX;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din_i = '0;
    logic [1:0]  din_ch_i = '0;
    logic        din_vld_i = 1'b0;
    logic [3:0]  shift_i = '0;
    logic        avg_en_i = 1'b0;
    logic        avg_clr_i = 1'b0;
    logic        ch_clr_i = 1'b0;
    logic [1:0]  ch_clr_sel_i = '0;
    logic [15:0] dout_o;
    logic [1:0]  dout_ch_o;
    logic        dout_update_o;
    logic        dout_settled_o;

    int passed = 0;
    int total  = 0;

    // Reference model: accumulator held as a plain integer scaled by 2^FRAC_W.
    longint m_acc  [4];
    int     m_cnt  [4];
    bit     m_seed [4];
    logic        e_upd = 1'b0;
    logic        e_set = 1'b0;
    logic [1:0]  e_ch = '0;
    logic [15:0] e_dout = '0;

    ste_avg_iir_mc #(
        .DATA_W    (DATA_W),
        .CH_N      (CH_N),
        .FRAC_W    (FRAC_W),
        .SHIFT_MAX (SHIFT_MAX)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .din_i          (din_i),
        .din_ch_i       (din_ch_i),
        .din_vld_i      (din_vld_i),
        .shift_i        (shift_i),
        .avg_en_i       (avg_en_i),
        .avg_clr_i      (avg_clr_i),
        .ch_clr_i       (ch_clr_i),
        .ch_clr_sel_i   (ch_clr_sel_i),
        .dout_o         (dout_o),
        .dout_ch_o      (dout_ch_o),
        .dout_update_o  (dout_update_o),
        .dout_settled_o (dout_settled_o)
    );

    always #5 clk = ~clk;

    function automatic longint floor_div(input longint n, input longint m);
        if (n >= 0) return n / m;
        return -((-n + m - 1) / m);
    endfunction

    // Drive one cycle of inputs, advance the model by the same rules, and
    // return #1 after the clock edge so outputs can be sampled.
    task automatic cyc(input bit rst, input bit vld, input int ch, input int d,
                       input int sh, input bit en = 1'b1, input bit aclr = 1'b0,
                       input bit cclr = 1'b0, input int csel = 0);
        int     k;
        bit     ok;
        longint x;
        rst_n        = rst;
        din_vld_i    = vld;
        din_ch_i     = 2'(ch);
        din_i        = 16'(d);
        shift_i      = 4'(sh);
        avg_en_i     = en;
        avg_clr_i    = aclr;
        ch_clr_i     = cclr;
        ch_clr_sel_i = 2'(csel);
        k = (sh > SHIFT_MAX) ? SHIFT_MAX : sh;
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                m_acc[i] = 0; m_cnt[i] = 0; m_seed[i] = 0;
            end
            e_upd = 0; e_set = 0; e_ch = 0; e_dout = 0;
        end else begin
            ok = vld && en && (ch < CH_N) && !aclr && !(cclr && csel == ch);
            e_upd = ok;
            if (ok) begin
                x = longint'(d) * (longint'(1) << FRAC_W);
                if (!m_seed[ch]) begin
                    m_acc[ch] = x; m_seed[ch] = 1; m_cnt[ch] = 1;
                end else begin
                    m_acc[ch] = m_acc[ch] + floor_div(x - m_acc[ch], longint'(1) << k);
                    m_cnt[ch] = (m_cnt[ch] + 1 > CNT_CAP) ? CNT_CAP : m_cnt[ch] + 1;
                end
                e_dout = 16'(m_acc[ch] / (longint'(1) << FRAC_W));
                e_ch   = 2'(ch);
                e_set  = (m_cnt[ch] >= (1 << k));
            end
            if (aclr) begin
                for (int i = 0; i < 4; i++) begin
                    m_acc[i] = 0; m_cnt[i] = 0; m_seed[i] = 0;
                end
            end else if (cclr && csel < CH_N) begin
                m_acc[csel] = 0; m_cnt[csel] = 0; m_seed[csel] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(0, 1, 0, 'h1234, 3);
        cyc(0, 0, 0, 0, 3);
        total++;
        if ({dout_update_o, dout_ch_o, dout_o, dout_settled_o} !== 20'h0) begin
            $display("FAIL reset_state: got upd=%0b ch=%0d dout=%h set=%0b, want all 0",
                     dout_update_o, dout_ch_o, dout_o, dout_settled_o);
        end else passed++;
    endtask

    task automatic test_seed();
        cyc(1, 1, 0, 'h0800, 3);
        total++;
        if ({dout_update_o, dout_ch_o, dout_o, dout_settled_o} !== {1'b1, 2'd0, 16'h0800, 1'b0}) begin
            $display("FAIL seed: got upd=%0b ch=%0d dout=%h set=%0b, want 1/0/0800/0",
                     dout_update_o, dout_ch_o, dout_o, dout_settled_o);
        end else passed++;
        cyc(1, 0, 0, 0, 3);
        total++;
        if (dout_update_o !== 1'b0 || dout_o !== 16'h0800) begin
            $display("FAIL seed_hold: got upd=%0b dout=%h, want 0/0800", dout_update_o, dout_o);
        end else passed++;
    endtask

    task automatic test_step();
        logic [15:0] want [2] = '{16'h0100, 16'h01E0};
        cyc(1, 0, 0, 0, 3, 1, 1);
        cyc(1, 1, 0, 'h0000, 3);
        for (int i = 2; i <= 10; i++) begin
            cyc(1, 1, 0, 'h0800, 3);
            if (i <= 3) begin
                total++;
                if (dout_o !== want[i-2]) begin
                    $display("FAIL step_value_%0d: got %h, want %h", i, dout_o, want[i-2]);
                end else passed++;
            end
            total++;
            if (dout_settled_o !== (i >= 8)) begin
                $display("FAIL step_settled_%0d: got %0b, want %0b", i, dout_settled_o, i >= 8);
            end else passed++;
            total++;
            if ({dout_update_o, dout_ch_o, dout_o, dout_settled_o} !== {e_upd, e_ch, e_dout, e_set}) begin
                $display("FAIL step_model_%0d: got %h, want %h", i,
                         {dout_update_o, dout_ch_o, dout_o, dout_settled_o}, {e_upd, e_ch, e_dout, e_set});
            end else passed++;
        end
    endtask

    task automatic test_interleave();
        cyc(1, 0, 0, 0, 3, 1, 1);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, i % 2, (i % 2) ? 'h0010 : 'h1000, 3);
            total++;
            if ({dout_update_o, dout_ch_o, dout_o, dout_settled_o} !==
                {1'b1, 2'(i % 2), ((i % 2) ? 16'h0010 : 16'h1000), (i / 2 + 1 >= 8)}) begin
                $display("FAIL interleave_%0d: got upd=%0b ch=%0d dout=%h set=%0b", i,
                         dout_update_o, dout_ch_o, dout_o, dout_settled_o);
            end else passed++;
        end
    endtask

    task automatic test_clear_priority();
        cyc(1, 1, 1, 'h1234, 3, 1, 0, 1, 1);
        total++;
        if (dout_update_o !== 1'b0 || dout_o !== 16'h0010 || dout_ch_o !== 2'd1) begin
            $display("FAIL chclr_drop: got upd=%0b dout=%h ch=%0d, want 0/0010/1",
                     dout_update_o, dout_o, dout_ch_o);
        end else passed++;
        cyc(1, 1, 1, 'h0200, 3);
        total++;
        if ({dout_update_o, dout_ch_o, dout_o, dout_settled_o} !== {1'b1, 2'd1, 16'h0200, 1'b0}) begin
            $display("FAIL chclr_reseed: got dout=%h set=%0b, want 0200/0", dout_o, dout_settled_o);
        end else passed++;
        cyc(1, 1, 0, 'h1000, 3);
        total++;
        if ({dout_update_o, dout_ch_o, dout_o, dout_settled_o} !== {1'b1, 2'd0, 16'h1000, 1'b1}) begin
            $display("FAIL chclr_other: got dout=%h set=%0b, want 1000/1", dout_o, dout_settled_o);
        end else passed++;
        cyc(1, 1, 0, 'h0400, 3, 1, 1);
        total++;
        if (dout_update_o !== 1'b0 || dout_o !== 16'h1000) begin
            $display("FAIL avgclr_drop: got upd=%0b dout=%h, want 0/1000", dout_update_o, dout_o);
        end else passed++;
        for (int c = 0; c < CH_N; c++) begin
            cyc(1, 1, c, 'h0300 + c * 'h111, 3);
            total++;
            if ({dout_update_o, dout_ch_o, dout_o, dout_settled_o} !==
                {1'b1, 2'(c), 16'(16'h0300 + c * 16'h111), 1'b0}) begin
                $display("FAIL avgclr_reseed_ch%0d: got dout=%h set=%0b", c, dout_o, dout_settled_o);
            end else passed++;
        end
    endtask

    task automatic test_passthrough_clamp();
        int d;
        for (int i = 0; i < 8; i++) begin
            d = $urandom_range(0, 65535);
            cyc(1, 1, i % CH_N, d, 0);
            total++;
            if ({dout_update_o, dout_o, dout_settled_o} !== {1'b1, 16'(d), 1'b1}) begin
                $display("FAIL passthrough_%0d: got dout=%h set=%0b, want %h/1", i, dout_o, dout_settled_o, d);
            end else passed++;
        end
        cyc(1, 0, 0, 0, 15, 1, 0, 1, 2);
        cyc(1, 1, 2, 'h0000, 15);
        cyc(1, 1, 2, 'h0800, 15);
        total++;
        if ({dout_o, dout_settled_o} !== {16'h0010, 1'b0}) begin
            $display("FAIL clamp_k15: got dout=%h set=%0b, want 0010/0", dout_o, dout_settled_o);
        end else passed++;
    endtask

    task automatic test_ignore();
        logic [15:0] held;
        cyc(1, 1, 0, 'h2222, 2);
        held = dout_o;
        cyc(1, 1, 0, 'hFFFF, 2, 0);
        total++;
        if (dout_update_o !== 1'b0 || dout_o !== held) begin
            $display("FAIL ignore_en: got upd=%0b dout=%h, want 0/%h", dout_update_o, dout_o, held);
        end else passed++;
        cyc(1, 1, 3, 'hFFFF, 2);
        total++;
        if (dout_update_o !== 1'b0 || dout_o !== held) begin
            $display("FAIL ignore_ch3: got upd=%0b dout=%h, want 0/%h", dout_update_o, dout_o, held);
        end else passed++;
        cyc(1, 1, 0, 'h3000, 2);
        total++;
        if ({dout_update_o, dout_ch_o, dout_o, dout_settled_o} !== {e_upd, e_ch, e_dout, e_set}) begin
            $display("FAIL ignore_state: got %h, want %h",
                     {dout_update_o, dout_ch_o, dout_o, dout_settled_o}, {e_upd, e_ch, e_dout, e_set});
        end else passed++;
        cyc(1, 1, 1, 'h4444, 3);
        cyc(0, 1, 1, 'h5555, 3);
        total++;
        if ({dout_update_o, dout_ch_o, dout_o, dout_settled_o} !== 20'h0) begin
            $display("FAIL reset_mid: got upd=%0b ch=%0d dout=%h set=%0b, want all 0",
                     dout_update_o, dout_ch_o, dout_o, dout_settled_o);
        end else passed++;
        cyc(1, 1, 1, 'h0ABC, 3);
        total++;
        if ({dout_update_o, dout_ch_o, dout_o, dout_settled_o} !== {1'b1, 2'd1, 16'h0ABC, 1'b0}) begin
            $display("FAIL reset_reseed: got dout=%h set=%0b, want 0ABC/0", dout_o, dout_settled_o);
        end else passed++;
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            cyc(1, $urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 65535),
                $urandom_range(0, 15), $urandom_range(0, 15) != 0, $urandom_range(0, 60) == 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 3));
            total++;
            if ({dout_update_o, dout_ch_o, dout_o, dout_settled_o} !== {e_upd, e_ch, e_dout, e_set}) begin
                if (bad < 10)
                    $display("FAIL random_%0d: got upd=%0b ch=%0d dout=%h set=%0b, want %0b/%0d/%h/%0b", i,
                             dout_update_o, dout_ch_o, dout_o, dout_settled_o, e_upd, e_ch, e_dout, e_set);
                bad++;
            end else passed++;
        end
    endtask

    task automatic test_back_to_back();
        cyc(1, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 12; i++) begin
            cyc(1, 1, 2, $urandom_range(0, 65535), 1);
            total++;
            if ({dout_update_o, dout_ch_o, dout_o, dout_settled_o} !== {e_upd, e_ch, e_dout, e_set}) begin
                $display("FAIL b2b_%0d: got %h, want %h", i,
                         {dout_update_o, dout_ch_o, dout_o, dout_settled_o}, {e_upd, e_ch, e_dout, e_set});
            end else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_seed();
        test_step();
        test_interleave();
        test_clear_priority();
        test_passthrough_clamp();
        test_ignore();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
